seven_seg_scan: RTL and testbench

Time-multiplexed driver for the 3-digit common-anode seven-segment display on the Mimas V2. It consumes the Hundreds/Tens/Ones BCD digits produced by the binary-to-BCD stage and scans them onto the shared segment bus with active-low digit enables. Inputs are captured once per frame so a digit never changes partway through a scan. A blanking gap between digits suppresses ghosting.

---
 rtl/seven_seg_pkg.sv | 47 ++++
 rtl/seven_seg_scan_if.sv | 26 ++
 rtl/bcd_to_7seg.sv | 18 +
 rtl/seven_seg_scan.sv | 129 ++++++++++++
 tb/tb_seven_seg_scan.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg -- shared definitions for the Mimas V2 seven-segment scanner.
//   - FSM state encoding (ST_BLANK, ST_SHOW)
//   - active-low segment patterns {dp,g,f,e,d,c,b,a}: SEG_0..SEG_9, SEG_DASH, SEG_OFF
//   - DIG_OFF: all three active-low digit enables released
//   - seg_decode(): BCD code to pattern, codes 10..15 map to a dash
package seven_seg_pkg;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic [7:0] SEG_0    = 8'hC0;
    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h92;
    localparam logic [7:0] SEG_6    = 8'h82;
    localparam logic [7:0] SEG_7    = 8'hF8;
    localparam logic [7:0] SEG_8    = 8'h80;
    localparam logic [7:0] SEG_9    = 8'h90;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    localparam logic [2:0] DIG_OFF  = 3'b111;

    // Bit 7 of every pattern is the decimal point; it is cleared to light it.
    localparam logic [7:0] SEG_DP_MASK = 8'h7F;

    function automatic logic [7:0] seg_decode(input logic [3:0] code);
        logic [7:0] pat;
        case (code)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if -- digit inputs and display pins of the seven-segment scanner.
//   i_Ones/i_Tens/i_Hundreds : BCD digits from the binary-to-BCD stage
//   i_Dp                     : decimal-point request per digit, bit0 = ones
//   o_Segments               : active-low {dp,g,f,e,d,c,b,a}
//   o_Enables                : active-low digit enables, bit0 = ones
//   o_Frame                  : one-cycle pulse when the inputs are captured
// master = digit source / pin observer, slave = the scanner.
interface seven_seg_scan_if;
    logic [3:0] i_Ones;
    logic [3:0] i_Tens;
    logic [3:0] i_Hundreds;
    logic [2:0] i_Dp;
    logic [7:0] o_Segments;
    logic [2:0] o_Enables;
    logic       o_Frame;

    modport master (
        output i_Ones, i_Tens, i_Hundreds, i_Dp,
        input  o_Segments, o_Enables, o_Frame
    );

    modport slave (
        input  i_Ones, i_Tens, i_Hundreds, i_Dp,
        output o_Segments, o_Enables, o_Frame
    );
endinterface

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg -- combinational BCD to active-low seven-segment decoder.
//   code : 4-bit BCD code; 10..15 show a dash
//   dp   : decimal point request, lights the dp segment
//   seg  : active-low pattern {dp,g,f,e,d,c,b,a}
module bcd_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg = seg_decode(code);
        if (dp) seg = seg & SEG_DP_MASK;
    end

endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan -- time-multiplexed driver for the 3-digit common-anode display.
// Each digit slot is BLANK_CYCLES of all-off followed by DIGIT_CYCLES lit, in the
// order ones, tens, hundreds. Digits are captured into shadow registers once per
// frame (start of the ones blank slot), so a frame never mixes old and new values.
//   i_clk : system clock
//   i_rst : synchronous active-high reset
//   bus   : seven_seg_scan_if.slave (digit inputs, segment/enable pins, frame pulse)
// Parameters: DIGIT_CYCLES (>= 2), BLANK_CYCLES (>= 1).
// Optional macro SEVSEG_LZ_BLANK_EN: leading-zero blanking of hundreds/tens.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    seven_seg_scan_if.slave bus
);

    localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] DIG_LOAD = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLK_LOAD = CW'(BLANK_CYCLES - 1);

    logic [0:0]      state;
    logic [1:0]      idx;
    logic [CW-1:0]   cnt;

    logic [2:0][3:0] sh_dig;   // [0]=ones, [1]=tens, [2]=hundreds
    logic [2:0]      sh_dp;
    logic [2:0]      sh_blank; // per-digit blank flag, only set with LZ blanking

    logic            capture;
    logic [3:0]      cur_dig;
    logic            cur_dp;
    logic            cur_blank;
    logic [7:0]      dec_seg;
    logic [7:0]      show_seg;

    // First cycle of the ones blank slot. After reset the counter is preloaded
    // for BLANK at index 0, so the first cycle out of reset captures too.
    assign capture = (state == ST_BLANK) && (idx == 2'd0) && (cnt == BLK_LOAD);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_BLANK;
            idx      <= 2'd0;
            cnt      <= BLK_LOAD;
            sh_dig   <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
        end else begin
            if (cnt == '0) begin
                if (state == ST_BLANK) begin
                    state <= ST_SHOW;
                    cnt   <= DIG_LOAD;
                end else begin
                    state <= ST_BLANK;
                    cnt   <= BLK_LOAD;
                    idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                end
            end else begin
                cnt <= cnt - 1'b1;
            end

            if (capture) begin
                sh_dig <= {bus.i_Hundreds, bus.i_Tens, bus.i_Ones};
                sh_dp  <= bus.i_Dp;
`ifdef SEVSEG_LZ_BLANK_EN
                // Tens is only a leading zero when hundreds is one as well.
                sh_blank[0] <= 1'b0;
                sh_blank[1] <= (bus.i_Hundreds == 4'd0) && (bus.i_Tens == 4'd0);
                sh_blank[2] <= (bus.i_Hundreds == 4'd0);
`else
                sh_blank    <= '0;
`endif
            end
        end
    end

    always_comb begin
        cur_dig   = sh_dig[0];
        cur_dp    = sh_dp[0];
        cur_blank = sh_blank[0];
        case (idx)
            2'd1: begin
                cur_dig   = sh_dig[1];
                cur_dp    = sh_dp[1];
                cur_blank = sh_blank[1];
            end
            2'd2: begin
                cur_dig   = sh_dig[2];
                cur_dp    = sh_dp[2];
                cur_blank = sh_blank[2];
            end
            default: ;
        endcase
    end

    bcd_to_7seg u_dec (
        .code (cur_dig),
        .dp   (cur_dp),
        .seg  (dec_seg)
    );

    // A blanked digit keeps its slot and still honours its decimal point.
    assign show_seg = cur_blank ? (cur_dp ? (SEG_OFF & SEG_DP_MASK) : SEG_OFF) : dec_seg;

    // Pins are registered from the current state, so they trail it by a cycle;
    // enables and segments switch on the same edge and never straddle a slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_Enables  <= DIG_OFF;
            bus.o_Segments <= SEG_OFF;
            bus.o_Frame    <= 1'b0;
        end else begin
            bus.o_Frame <= capture;
            if (state == ST_SHOW) begin
                bus.o_Enables  <= ~(3'b001 << idx);
                bus.o_Segments <= show_seg;
            end else begin
                bus.o_Enables  <= DIG_OFF;
                bus.o_Segments <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan -- directed + randomized bench for seven_seg_scan.
// The reference model derives the expected pins from the cycle position inside
// the frame (slot = position / (BLANK+DIGIT), blank for the first BLANK cycles
// of each slot) and a digit lookup table, with inputs snapshotted at frame start.
module tb_seven_seg_scan;

    localparam int D     = 8;
    localparam int B     = 2;
    localparam int SLOT  = D + B;
    localparam int FRAME = 3 * SLOT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seven_seg_scan_if bus ();

    seven_seg_scan #(
        .DIGIT_CYCLES (D),
        .BLANK_CYCLES (B)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         t     = 0;      // cycles since reset release, output-aligned
    logic [3:0] m_dig [3];      // model shadow digits, [0] = ones
    logic [2:0] m_dp;
    logic [7:0] prev_seg = 8'hFF;
    logic [2:0] prev_en  = 3'b111;

    function automatic logic [7:0] ref_seg(input int code, input bit dp, input bit blank);
        logic [7:0] tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        logic [7:0] p;
        if (blank)          p = 8'hFF;
        else if (code > 9)  p = 8'hBF;
        else                p = tab[code];
        if (dp) p[7] = 1'b0;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s at t=%0d: observed %h expected %h", tag, t, obs, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] h, input logic [3:0] tn,
                          input logic [3:0] o, input logic [2:0] dp);
        bus.i_Hundreds = h;
        bus.i_Tens     = tn;
        bus.i_Ones     = o;
        bus.i_Dp       = dp;
    endtask

    // One clock: snapshot inputs at frame start, then check pins #1 after the edge.
    task automatic tick();
        logic [2:0] e_en;
        logic [7:0] e_seg;
        logic       e_fr;
        int         pos, slot, w;
        bit         bl;
        @(posedge clk);
        if (!rst && (t % FRAME) == 0) begin
            m_dig[0] = bus.i_Ones;
            m_dig[1] = bus.i_Tens;
            m_dig[2] = bus.i_Hundreds;
            m_dp     = bus.i_Dp;
        end
        #1;
        if (rst) begin
            e_en  = 3'b111;
            e_seg = 8'hFF;
            e_fr  = 1'b0;
            t     = 0;
        end else begin
            pos  = t % FRAME;
            slot = pos / SLOT;
            w    = pos % SLOT;
            e_fr = (pos == 0);
            if (w < B) begin
                e_en  = 3'b111;
                e_seg = 8'hFF;
            end else begin
                e_en       = 3'b111;
                e_en[slot] = 1'b0;
                bl         = 1'b0;
`ifdef SEVSEG_LZ_BLANK_EN
                if (slot == 2) bl = (m_dig[2] == 0);
                if (slot == 1) bl = (m_dig[2] == 0) && (m_dig[1] == 0);
`endif
                e_seg = ref_seg(m_dig[slot], m_dp[slot], bl);
            end
            t++;
        end
        chk("enables",  {5'b0, bus.o_Enables}, {5'b0, e_en});
        chk("segments", bus.o_Segments, e_seg);
        chk("frame",    {7'b0, bus.o_Frame}, {7'b0, e_fr});
        chk("one_enable", {7'b0, ($countones(~bus.o_Enables) <= 1)}, 8'd1);
        chk("seg_stable_while_lit",
            {7'b0, (bus.o_Segments == prev_seg) || (bus.o_Enables == 3'b111) || (prev_en == 3'b111)},
            8'd1);
        prev_seg = bus.o_Segments;
        prev_en  = bus.o_Enables;
    endtask

    initial begin
        set_in(4'd1, 4'd2, 4'd3, 3'b000);
        rst = 1'b1;
        repeat (4) tick();               // held reset: reset pins, no frame pulse
        rst = 1'b0;
        repeat (FRAME) tick();           // 1,2,3: ones B0, tens A4, hundreds F9

        // Ones 4 for a frame, switched to 7 during the tens slot.
        set_in(4'd1, 4'd2, 4'd4, 3'b000);
        while ((t % FRAME) != 0) tick();
        repeat (SLOT + B + 3) tick();
        set_in(4'd1, 4'd2, 4'd7, 3'b000);
        repeat (2 * FRAME) tick();

        // Dash with decimal point on the ones digit, zero leading digits.
        set_in(4'd0, 4'd0, 4'd12, 3'b001);
        repeat (FRAME) tick();

        // 0,0,5: leading zeros (blank or C0 depending on build).
        set_in(4'd0, 4'd0, 4'd5, 3'b000);
        repeat (FRAME) tick();

        // Hundreds = 0 but tens nonzero, dp on the hundreds digit.
        set_in(4'd0, 4'd3, 4'd9, 3'b100);
        repeat (FRAME) tick();

        // One-cycle reset in the middle of the hundreds SHOW slot.
        set_in(4'd6, 4'd8, 4'd0, 3'b010);
        while ((t % FRAME) != (2 * SLOT + B + 3)) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (FRAME) tick();

        // Ten frames of random digits/dp changing at random cycles.
        for (int i = 0; i < 10 * FRAME; i++) begin
            if ($urandom_range(0, 6) == 0)
                set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
